// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage. Owns HI/LO, models fixed
// multi-cycle latency, and exposes busy so md/mt/mf instructions can stall.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  mduOp,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_pend_hi, r_pend_lo;
  logic          r_pend_wr;

  logic          w_idle, w_is_md, w_is_mult, w_issue, w_commit, w_mthi, w_mtlo;
  logic [63:0]   w_prod_s, w_prod_u;
  logic          w_div_zero;
  logic [31:0]   w_divisor, w_a_mag, w_b_mag, w_sq, w_sr, w_uq, w_ur;
  logic [31:0]   w_res_hi, w_res_lo;
  logic          w_res_wr;

  // Issue / move-to / commit qualification
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_is_md   = (mduOp inside {[4'd1:4'd4]});
    w_is_mult = (mduOp == 4'd1) || (mduOp == 4'd2);
    w_issue   = start && !req && w_idle && w_is_md;
    w_mthi    = (mduOp == 4'd5) && !req && w_idle;
    w_mtlo    = (mduOp == 4'd6) && !req && w_idle;
    w_commit  = (r_state == S_RUN) && (r_cnt == CW'(1));
  end

  // Next-state logic for the IDLE/RUN controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_issue)  w_state_nxt = S_RUN;
      S_RUN:  if (w_commit) w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Arithmetic: signed divide is done on magnitudes so that
  // 0x80000000 / -1 wraps cleanly instead of relying on signed overflow;
  // a zero divisor is replaced by 1 to keep the datapath X-free.
  always_comb begin
    w_prod_s   = 64'($signed(d1)) * 64'($signed(d2));
    w_prod_u   = {32'b0, d1} * {32'b0, d2};
    w_div_zero = (d2 == '0);
    w_divisor  = w_div_zero ? 32'd1 : d2;
    w_a_mag    = d1[31] ? -d1 : d1;
    w_b_mag    = d2[31] ? -w_divisor : w_divisor;
    w_sq       = w_a_mag / w_b_mag;
    w_sr       = w_a_mag % w_b_mag;
    w_uq       = d1 / w_divisor;
    w_ur       = d1 % w_divisor;

    w_res_hi = '0;
    w_res_lo = '0;
    w_res_wr = 1'b0;
    case (mduOp)
      4'd1: begin {w_res_hi, w_res_lo} = w_prod_s; w_res_wr = 1'b1; end
      4'd2: begin {w_res_hi, w_res_lo} = w_prod_u; w_res_wr = 1'b1; end
      4'd3: begin
        w_res_lo = (d1[31] ^ d2[31]) ? -w_sq : w_sq;
        w_res_hi = d1[31] ? -w_sr : w_sr;
        w_res_wr = !w_div_zero;
      end
      4'd4: begin
        w_res_lo = w_uq;
        w_res_hi = w_ur;
        w_res_wr = !w_div_zero;
      end
      default: ;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Latency counter and pending result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else if (w_issue) begin
      r_cnt     <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_wr <= w_res_wr;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Architectural HI/LO: commit at end of busy period, or mthi/mtlo
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (w_commit) begin
      if (r_pend_wr) begin
        hi <= r_pend_hi;
        lo <= r_pend_lo;
      end
    end else begin
      if (w_mthi) hi <= d1;
      if (w_mtlo) lo <= d1;
    end
  end

  assign busy = (r_state == S_RUN);

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the P7 pipelined MIPS core.
- Directly consumes the decoder's `mduOp`, `mdu_start` and the forwarded `rs`/`rt` operands.
- Owns the HI/LO registers and exposes `busy` so the hazard unit can stall md/mt/mf instructions behind an in-flight operation.
- Models fixed multi-cycle multiply/divide latency and suppresses state updates for instructions squashed by an exception/interrupt request.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- mduOp  input  4  decoded op: 1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo; others = no-op
- start  input  1  `mdu_start` from decoder, high for mult/multu/div/divu in EX
- req  input  1  exception/interrupt flush of current EX instruction; blocks all new writes this cycle
- d1  input  32  forwarded rs value
- d2  input  32  forwarded rt value
- busy  output  1  operation in flight
- hi  output  32  HI register (mfhi source)
- lo  output  32  LO register (mflo source)

Behaviour:
- Reset (async, `reset_n`=0): hi=0, lo=0, busy=0, counter=0, pending result regs=0. Reset mid-operation aborts it; no commit occurs afterwards.
- State: IDLE (busy=0) / RUN (busy=1). A down-counter (≥4 bits, wide enough for max(MULT_CYCLES,DIV_CYCLES)) plus 32-bit pend_hi/pend_lo.
- Issue: at a rising edge with start=1, req=0, busy=0 and mduOp in 1..4:
  - compute result from d1/d2 into pend_hi/pend_lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - busy=1 from the next cycle.
- Latency: issue at edge E0 gives busy=1 for exactly N cycles (E0..E0+N). At edge E0+N: hi/lo ← pend, busy→0. New hi/lo are visible in the cycle after busy falls.
- mult: {hi,lo} = signed(d1)×signed(d2), 64-bit.
- multu: {hi,lo} = unsigned 64-bit product.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: lo = unsigned quotient, hi = unsigned remainder.
- Divide by zero (d2=0) for div/divu:
  - full DIV_CYCLES busy period still occurs;
  - commit leaves hi/lo unchanged;
  - no X propagation.
- mthi/mtlo: at an edge with mduOp=5/6, req=0, busy=0, hi or lo ← d1. Single cycle, busy unaffected. `start` is ignored for these codes.
- req=1 in a cycle: no issue and no mthi/mtlo write at that edge. An operation already in RUN continues and commits normally, since it was issued by an earlier, non-flushed instruction.
- start=1 or mt op while busy=1: ignored. This is a protocol violation, because the hazard unit must stall; the verification bench flags it with an assertion.
- start=1 with mduOp outside 1..4: ignored.
- Outputs hi/lo are registered values and are never combinationally bypassed from pend.
- At most one operation in flight; no queueing.

Test Plan:
- mult: d1=0xFFFFFFFD (−3), d2=5, start pulse → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. hi/lo keep their old values while busy.
- multu and divu:
  - multu d1=0xFFFFFFFF, d2=2 → hi=1, lo=0xFFFFFFFE after 5 cycles;
  - divu d1=100, d2=7 → lo=14, hi=2 after exactly 10 busy cycles.
- div signs and overflow:
  - d1=0xFFFFFFF9 (−7), d2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - d1=0x80000000, d2=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo; div d2=0 → busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- req gating:
  - mtlo d1=0xABCD with req=1 → lo unchanged;
  - mult with req=1 → busy never rises;
  - req=1 raised while a div is running → div still commits correct result.
- Reset mid-op: start mult, deassert `reset_n` at busy cycle 2 → immediately busy=0, hi=lo=0; after release, no late commit occurs.
